// File: rtl/stack_pkg.sv
// Shared definitions for the LIFO stack: operation encoding and a constant clog2 helper.
package stack_pkg;

  typedef logic [1:0] op_t;

  localparam op_t OP_NOP     = 2'd0;
  localparam op_t OP_PUSH    = 2'd1;
  localparam op_t OP_POP     = 2'd2;
  localparam op_t OP_REPLACE = 2'd3;

  // Number of bits needed to index 'value' distinct items (0 for value <= 1).
  function automatic int clog2(input int value);
    int bits;
    int rem;
    bits = 0;
    rem  = value - 1;
    while (rem > 0) begin
      bits++;
      rem = rem >> 1;
    end
    return bits;
  endfunction

endpackage

// File: rtl/stack_mem.sv
// DEPTH x WIDTH register file: one synchronous write port, async pop read port and,
// when STACK_PEEK_EN is defined, a second async read port for peek.
module stack_mem
  import stack_pkg::*;
#(
  parameter  int WIDTH = 8,
  parameter  int DEPTH = 16,
  localparam int AW    = clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             i_we,
  input  logic [AW-1:0]    i_waddr,
  input  logic [WIDTH-1:0] i_wdata,
  input  logic [AW-1:0]    i_raddr_a,
  output logic [WIDTH-1:0] o_rdata_a
`ifdef STACK_PEEK_EN
  ,
  input  logic [AW-1:0]    i_raddr_b,
  output logic [WIDTH-1:0] o_rdata_b
`endif
);

  logic [WIDTH-1:0] r_mem [DEPTH];

  // NOTE: the storage array has no reset; occupancy is tracked by the count register alone.
  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
  end

  assign o_rdata_a = r_mem[i_raddr_a];

`ifdef STACK_PEEK_EN
  assign o_rdata_b = r_mem[i_raddr_b];
`endif

endmodule

// File: rtl/param_stack.sv
// Parametrised LIFO with registered pop data, occupancy count and sticky error flags.
// Optional peek ports enabled by defining STACK_PEEK_EN.
module param_stack
  import stack_pkg::*;
#(
  parameter  int WIDTH = 8,
  parameter  int DEPTH = 16,
  localparam int CW    = clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  input  logic             err_clr,
  output logic [WIDTH-1:0] dout,
  output logic             dout_valid,
  output logic [CW-1:0]    count,
  output logic             empty,
  output logic             full,
  output logic             overflow,
  output logic             underflow
`ifdef STACK_PEEK_EN
  ,
  output logic [WIDTH-1:0] peek,
  output logic             peek_valid
`endif
);

  localparam int AW = clog2(DEPTH);

  logic [CW-1:0]    r_count;
  logic [WIDTH-1:0] r_dout;
  logic             r_dout_valid;
  logic             r_overflow;
  logic             r_underflow;

  logic             w_empty;
  logic             w_full;
  op_t              w_op;
  logic             w_ovf_set;
  logic             w_udf_set;
  logic             w_we;
  logic [AW-1:0]    w_top_addr;
  logic [AW-1:0]    w_wr_addr;
  logic [WIDTH-1:0] w_top_data;

  assign w_empty    = (r_count == '0);
  assign w_full     = (r_count == CW'(DEPTH));
  // Clamp to entry 0 when empty so the read address never leaves the array.
  assign w_top_addr = w_empty ? '0 : AW'(r_count - CW'(1));

  // NOTE: every output of this block gets a default first, so no path can infer a latch.
  always_comb begin
    w_op      = OP_NOP;
    w_ovf_set = 1'b0;
    w_udf_set = 1'b0;
    if (push && pop) begin
      w_op = w_empty ? OP_PUSH : OP_REPLACE;
    end else if (push) begin
      if (w_full) w_ovf_set = 1'b1;
      else        w_op      = OP_PUSH;
    end else if (pop) begin
      if (w_empty) w_udf_set = 1'b1;
      else         w_op      = OP_POP;
    end
  end

  assign w_we      = !rst && ((w_op == OP_PUSH) || (w_op == OP_REPLACE));
  assign w_wr_addr = (w_op == OP_REPLACE) ? w_top_addr : AW'(r_count);

  stack_mem #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_mem (
    .clk       (clk),
    .i_we      (w_we),
    .i_waddr   (w_wr_addr),
    .i_wdata   (din),
    .i_raddr_a (w_top_addr),
    .o_rdata_a (w_top_data)
`ifdef STACK_PEEK_EN
    ,
    .i_raddr_b (w_top_addr),
    .o_rdata_b (peek)
`endif
  );

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_count      <= '0;
      r_dout       <= '0;
      r_dout_valid <= 1'b0;
      r_overflow   <= 1'b0;
      r_underflow  <= 1'b0;
    end else begin
      r_dout_valid <= 1'b0;
      case (w_op)
        OP_PUSH: r_count <= r_count + CW'(1);
        OP_POP: begin
          r_count      <= r_count - CW'(1);
          r_dout       <= w_top_data;
          r_dout_valid <= 1'b1;
        end
        OP_REPLACE: begin
          r_dout       <= w_top_data;
          r_dout_valid <= 1'b1;
        end
        default: ;
      endcase
      // Clear wins over a same-cycle set.
      if (err_clr)        r_overflow <= 1'b0;
      else if (w_ovf_set) r_overflow <= 1'b1;
      if (err_clr)        r_underflow <= 1'b0;
      else if (w_udf_set) r_underflow <= 1'b1;
    end
  end

  assign dout       = r_dout;
  assign dout_valid = r_dout_valid;
  assign count      = r_count;
  assign empty      = w_empty;
  assign full       = w_full;
  assign overflow   = r_overflow;
  assign underflow  = r_underflow;

`ifdef STACK_PEEK_EN
  assign peek_valid = !w_empty;
`endif

endmodule

// File: tb/tb_param_stack.sv
// Self-checking bench for param_stack: directed vector table, multi-cycle sequences and
// randomized traffic against a queue-based reference model.
module tb_param_stack;

  localparam int WIDTH = 8;
  localparam int DEPTH = 16;
  localparam int CW    = 5;

  logic             clk;
  logic             rst;
  logic             push;
  logic             pop;
  logic [WIDTH-1:0] din;
  logic             err_clr;
  logic [WIDTH-1:0] dout;
  logic             dout_valid;
  logic [CW-1:0]    count;
  logic             empty;
  logic             full;
  logic             overflow;
  logic             underflow;
`ifdef STACK_PEEK_EN
  logic [WIDTH-1:0] peek;
  logic             peek_valid;
`endif

  param_stack #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .push       (push),
    .pop        (pop),
    .din        (din),
    .err_clr    (err_clr),
    .dout       (dout),
    .dout_valid (dout_valid),
    .count      (count),
    .empty      (empty),
    .full       (full),
    .overflow   (overflow),
    .underflow  (underflow)
`ifdef STACK_PEEK_EN
    ,
    .peek       (peek),
    .peek_valid (peek_valid)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_total = 0;
  int n_bad   = 0;

  // Reference model: a queue whose back is the top of stack.
  logic [WIDTH-1:0] mq[$];
  logic [WIDTH-1:0] m_dout;
  logic             m_vld;
  logic             m_ovf;
  logic             m_udf;

  typedef struct {
    logic             rst;
    logic             push;
    logic             pop;
    logic             clr;
    logic [WIDTH-1:0] din;
    int               cnt;
    logic [WIDTH-1:0] dout;
    logic             vld;
    logic             ovf;
    logic             udf;
  } vec_t;

  vec_t tbl[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_step(input logic r, input logic p, input logic pp,
                            input logic [WIDTH-1:0] d, input logic c);
    logic ovf_set;
    logic udf_set;
    ovf_set = 1'b0;
    udf_set = 1'b0;
    if (r) begin
      mq.delete();
      m_dout = '0;
      m_vld  = 1'b0;
      m_ovf  = 1'b0;
      m_udf  = 1'b0;
      return;
    end
    m_vld = 1'b0;
    if (p && pp) begin
      if (mq.size() == 0) begin
        mq.push_back(d);
      end else begin
        m_dout = mq[$];
        m_vld  = 1'b1;
        mq[mq.size()-1] = d;
      end
    end else if (p) begin
      if (mq.size() == DEPTH) ovf_set = 1'b1;
      else                    mq.push_back(d);
    end else if (pp) begin
      if (mq.size() == 0) begin
        udf_set = 1'b1;
      end else begin
        m_dout = mq.pop_back();
        m_vld  = 1'b1;
      end
    end
    if (c)            m_ovf = 1'b0;
    else if (ovf_set) m_ovf = 1'b1;
    if (c)            m_udf = 1'b0;
    else if (udf_set) m_udf = 1'b1;
  endtask

  // Drive one cycle of inputs, let the edge happen, advance the model.
  task automatic drive(input logic r, input logic p, input logic pp,
                       input logic [WIDTH-1:0] d, input logic c);
    rst     = r;
    push    = p;
    pop     = pp;
    din     = d;
    err_clr = c;
    @(posedge clk);
    #1;
    model_step(r, p, pp, d, c);
  endtask

  task automatic check_model(input string tag);
    check({tag, ".count"}, 32'(count), 32'(mq.size()));
    check({tag, ".empty"}, 32'(empty), 32'(mq.size() == 0));
    check({tag, ".full"}, 32'(full), 32'(mq.size() == DEPTH));
    check({tag, ".dout"}, 32'(dout), 32'(m_dout));
    check({tag, ".dout_valid"}, 32'(dout_valid), 32'(m_vld));
    check({tag, ".overflow"}, 32'(overflow), 32'(m_ovf));
    check({tag, ".underflow"}, 32'(underflow), 32'(m_udf));
`ifdef STACK_PEEK_EN
    check({tag, ".peek_valid"}, 32'(peek_valid), 32'(mq.size() != 0));
    if (mq.size() != 0) check({tag, ".peek"}, 32'(peek), 32'(mq[$]));
`endif
  endtask

  task automatic apply(input string tag, input logic r, input logic p, input logic pp,
                       input logic [WIDTH-1:0] d, input logic c);
    drive(r, p, pp, d, c);
    check_model(tag);
  endtask

  initial begin
    rst     = 1'b1;
    push    = 1'b0;
    pop     = 1'b0;
    din     = '0;
    err_clr = 1'b0;
    m_dout  = '0;
    m_vld   = 1'b0;
    m_ovf   = 1'b0;
    m_udf   = 1'b0;

    // Directed table: rst, push, pop, clr, din | count, dout, dout_valid, overflow, underflow
    tbl.push_back('{1, 0, 0, 0, 8'h00,  0, 8'h00, 0, 0, 0});  // reset cycle 1
    tbl.push_back('{1, 0, 0, 0, 8'h00,  0, 8'h00, 0, 0, 0});  // reset cycle 2
    tbl.push_back('{0, 0, 1, 0, 8'h00,  0, 8'h00, 0, 0, 1});  // pop on empty
    tbl.push_back('{0, 0, 0, 1, 8'h00,  0, 8'h00, 0, 0, 0});  // clear flags
    tbl.push_back('{0, 1, 1, 0, 8'h5A,  1, 8'h00, 0, 0, 0});  // push+pop on empty = push
    tbl.push_back('{1, 0, 0, 0, 8'h00,  0, 8'h00, 0, 0, 0});
    tbl.push_back('{0, 1, 0, 0, 8'h01,  1, 8'h00, 0, 0, 0});
    tbl.push_back('{0, 1, 0, 0, 8'h02,  2, 8'h00, 0, 0, 0});
    tbl.push_back('{0, 1, 1, 0, 8'h33,  2, 8'h02, 1, 0, 0});  // replace top
    tbl.push_back('{0, 0, 0, 0, 8'h00,  2, 8'h02, 0, 0, 0});  // dout holds
    tbl.push_back('{0, 0, 1, 0, 8'h00,  1, 8'h33, 1, 0, 0});
    tbl.push_back('{0, 0, 1, 0, 8'h00,  0, 8'h01, 1, 0, 0});
    tbl.push_back('{0, 0, 1, 0, 8'h00,  0, 8'h01, 0, 0, 1});  // underflow, dout unchanged
    tbl.push_back('{0, 0, 1, 1, 8'h00,  0, 8'h01, 0, 0, 0});  // clear beats same-cycle set

    foreach (tbl[i]) begin
      drive(tbl[i].rst, tbl[i].push, tbl[i].pop, tbl[i].din, tbl[i].clr);
      check($sformatf("vec%0d.count", i), 32'(count), 32'(tbl[i].cnt));
      check($sformatf("vec%0d.empty", i), 32'(empty), 32'(tbl[i].cnt == 0));
      check($sformatf("vec%0d.full", i), 32'(full), 32'(tbl[i].cnt == DEPTH));
      check($sformatf("vec%0d.dout", i), 32'(dout), 32'(tbl[i].dout));
      check($sformatf("vec%0d.dout_valid", i), 32'(dout_valid), 32'(tbl[i].vld));
      check($sformatf("vec%0d.overflow", i), 32'(overflow), 32'(tbl[i].ovf));
      check($sformatf("vec%0d.underflow", i), 32'(underflow), 32'(tbl[i].udf));
    end

    // Fill 0x11..0x20 then drain: LIFO order, each word one cycle after its pop.
    apply("t2.rst", 1, 0, 0, 8'h00, 0);
    for (int i = 0; i < DEPTH; i++) apply("t2.push", 0, 1, 0, 8'(8'h11 + i), 0);
    check("t2.full", 32'(full), 32'd1);
    for (int i = 0; i < DEPTH; i++) begin
      apply("t2.pop", 0, 0, 1, 8'h00, 0);
      check("t2.seq", 32'(dout), 32'(8'h20 - i));
    end
    check("t2.empty", 32'(empty), 32'd1);

    // Overflow: the rejected word must not land on the stack.
    for (int i = 0; i < DEPTH; i++) apply("t3.fill", 0, 1, 0, 8'(8'h11 + i), 0);
    apply("t3.ovf", 0, 1, 0, 8'hAA, 0);
    check("t3.ovf_flag", 32'(overflow), 32'd1);
    check("t3.ovf_count", 32'(count), 32'd16);
    apply("t3.clr", 0, 0, 0, 8'h00, 1);
    check("t3.ovf_cleared", 32'(overflow), 32'd0);
    apply("t3.pop", 0, 0, 1, 8'h00, 0);
    check("t3.pop_data", 32'(dout), 32'h20);
    apply("t3.replace_full", 0, 1, 0, 8'h77, 0);
    apply("t3.replace_full", 0, 1, 1, 8'h88, 0);
    check("t3.replace_full_dout", 32'(dout), 32'h77);

    // Reset during a pop discards it.
    apply("t6.rst", 1, 0, 0, 8'h00, 0);
    for (int i = 0; i < 3; i++) apply("t6.push", 0, 1, 0, 8'(8'hC0 + i), 0);
    apply("t6.rst_pop", 1, 0, 1, 8'h00, 0);
    check("t6.count", 32'(count), 32'd0);
    check("t6.valid", 32'(dout_valid), 32'd0);
    apply("t6.after", 0, 0, 0, 8'h00, 0);
    check("t6.valid_after", 32'(dout_valid), 32'd0);

    // Randomized traffic: fill-biased, then drain-biased, to hit both bounds repeatedly.
    for (int i = 0; i < 800; i++) begin
      int  bias;
      logic r, p, pp, c;
      bias = ((i / 100) % 2 == 0) ? 75 : 25;
      r  = ($urandom_range(0, 199) == 0);
      p  = ($urandom_range(0, 99) < bias);
      pp = ($urandom_range(0, 99) < (100 - bias));
      c  = ($urandom_range(0, 15) == 0);
      apply("rand", r, p, pp, 8'($urandom), c);
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
